// File: rtl/serial_word_collector_pkg.sv
// Shared state encodings and counter-width helper for the bit-serial datapath blocks.
package serial_word_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } coll_state_e;

    // Bit-position counter width for a word of the given length (at least one bit).
    function automatic int count_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_word_collector_shift_reg.sv
// LSB-first word assembly register: load starts a new word at bit 0, write places a bit at pos_i.
// Latency: storage updates on the next clock edge; word_o combines the incoming last bit combinationally.
// Backpressure: none; the caller only asserts load/write for accepted bits.
module serial_shift_reg
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = count_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] pos_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d    = '0;
            shreg_d[0] = bit_i;
        end else if (wr_i) begin
            shreg_d[pos_i] = bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The completing bit lands in the MSB without waiting for the register to update.
    assign word_o = {bit_i, shreg_q[WIDTH-2:0]};

endmodule

// File: rtl/serial_word_collector.sv
// Collects an LSB-first framed bit stream into WIDTH-bit words; COLLECTOR_MINNEG_FLAG_EN adds min_neg.
// Latency: word_valid rises the cycle after the WIDTH-th bit is accepted.
// Backpressure: bit_ready drops while a finished word waits for word_ready.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_start,
    output logic             bit_ready,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             frame_abort,
    output logic             sync_err
`ifdef COLLECTOR_MINNEG_FLAG_EN
    ,
    output logic             min_neg
`endif
);

    localparam int               CNT_W   = count_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    coll_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             abort_q, abort_d;
    logic             sync_q, sync_d;
    logic             shr_load;
    logic             shr_wr;
    logic             accept;
    logic [WIDTH-1:0] word_full;

    serial_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (shr_load),
        .wr_i   (shr_wr),
        .pos_i  (count_q),
        .bit_i  (bit_in),
        .word_o (word_full)
    );

    assign bit_ready = (state_q != HOLD) | word_ready;
    assign accept    = bit_valid & bit_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        word_d   = word_q;
        abort_d  = 1'b0;
        sync_d   = 1'b0;
        shr_load = 1'b0;
        shr_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (frame_start) begin
                        shr_load = 1'b1;
                        count_d  = CNT_W'(1);
                        state_d  = COLLECT;
                    end else begin
                        sync_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (frame_start) begin
                        shr_load = 1'b1;
                        count_d  = CNT_W'(1);
                        abort_d  = 1'b1;
                    end else if (count_q == LAST) begin
                        word_d  = word_full;
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        shr_wr  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Handshake and a new framed bit may coincide, giving back-to-back words.
                if (word_ready) begin
                    state_d = IDLE;
                    if (bit_valid) begin
                        if (frame_start) begin
                            shr_load = 1'b1;
                            count_d  = CNT_W'(1);
                            state_d  = COLLECT;
                        end else begin
                            sync_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            abort_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            abort_q <= abort_d;
            sync_q  <= sync_d;
        end
    end

    assign word_valid  = (state_q == HOLD);
    assign word_out    = word_q;
    assign frame_abort = abort_q;
    assign sync_err    = sync_q;

`ifdef COLLECTOR_MINNEG_FLAG_EN
    logic min_neg_q, min_neg_d;

    always_comb begin
        min_neg_d = min_neg_q;
        if (state_q == COLLECT && accept && !frame_start && count_q == LAST) begin
            min_neg_d = (word_full == MIN_NEG);
        end else if (state_q == HOLD && word_ready) begin
            min_neg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_neg_q <= 1'b0;
        end else begin
            min_neg_q <= min_neg_d;
        end
    end

    assign min_neg = min_neg_q;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector at WIDTH=32 and WIDTH=4 with a bit-level reference model.
module tb_serial_word_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, bv, bin, fs, word_ready;
    int   sel;
    int   cyc = 0;
    int   stall_until = 0;
    bit   rand_rdy = 0;
    int   total = 0;
    int   bad = 0;

    logic        bv0, bv1;
    logic        br0, wv0, fa0, se0, br1, wv1, fa1, se1;
    logic [31:0] wo0;
    logic [3:0]  wo1;
`ifdef COLLECTOR_MINNEG_FLAG_EN
    logic        mn0, mn1;
`endif

    assign bv0 = bv && (sel == 0);
    assign bv1 = bv && (sel == 1);

    serial_word_collector #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bv0), .bit_in(bin), .frame_start(fs),
        .bit_ready(br0), .word_valid(wv0), .word_ready(word_ready), .word_out(wo0),
        .frame_abort(fa0), .sync_err(se0)
`ifdef COLLECTOR_MINNEG_FLAG_EN
        , .min_neg(mn0)
`endif
    );

    serial_word_collector #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bv1), .bit_in(bin), .frame_start(fs),
        .bit_ready(br1), .word_valid(wv1), .word_ready(word_ready), .word_out(wo1),
        .frame_abort(fa1), .sync_err(se1)
`ifdef COLLECTOR_MINNEG_FLAG_EN
        , .min_neg(mn1)
`endif
    );

    logic [1:0]  wvv, brv, fav, sev, mnv;
    logic [31:0] wov [2];
    assign wvv    = {wv1, wv0};
    assign brv    = {br1, br0};
    assign fav    = {fa1, fa0};
    assign sev    = {se1, se0};
    assign wov[0] = wo0;
    assign wov[1] = {28'd0, wo1};
`ifdef COLLECTOR_MINNEG_FLAG_EN
    assign mnv = {mn1, mn0};
`else
    assign mnv = 2'b00;
`endif

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        mn;
        int          stamp;
    } wexp_t;
    typedef struct {
        int dut;
        int kind;   // 1 = frame_abort, 2 = sync_err
    } ev_t;

    wexp_t exp_q[$];
    ev_t   ev_q[$];

    // Reference model: framing flag, bits gathered so far and their value, per instance.
    bit          m_in  [2];
    int          m_cnt [2];
    logic [31:0] m_acc [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cyc < stall_until)      word_ready = 1'b0;
        else if (rand_rdy)          word_ready = 1'($urandom_range(0, 1));
        else                        word_ready = 1'b1;
    end

    // Monitor: pops expectations whenever a DUT presents a word or a pulse.
    logic [1:0]  pv, pstall, phs;
    logic [31:0] pwo [2];
    always @(negedge clk) begin
        if (!rst_n) begin
            pv     <= 2'b00;
            pstall <= 2'b00;
            phs    <= 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("bit_ready[%0d]", d), 32'(brv[d]), 32'(!(wvv[d] && !word_ready)));
                if (pstall[d]) begin
                    check($sformatf("stall_valid[%0d]", d), 32'(wvv[d]), 32'd1);
                    check($sformatf("stall_data[%0d]", d), wov[d], pwo[d]);
                end
                if (phs[d]) check($sformatf("valid_after_take[%0d]", d), 32'(wvv[d]), 32'd0);
                if (!wvv[d]) check($sformatf("min_neg_idle[%0d]", d), 32'(mnv[d]), 32'd0);
                if (wvv[d] && !pv[d]) begin
                    if (exp_q.size() > 0 && exp_q[0].dut == d)
                        check($sformatf("latency[%0d]", d), 32'(cyc), 32'(exp_q[0].stamp));
                    else
                        check($sformatf("unexpected_word[%0d]", d), wov[d], 32'hxxxx_xxxx);
                end
                if (wvv[d] && word_ready) begin
                    if (exp_q.size() > 0 && exp_q[0].dut == d) begin
                        wexp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("word[%0d]", d), wov[d], e.data);
`ifdef COLLECTOR_MINNEG_FLAG_EN
                        check($sformatf("min_neg[%0d]", d), 32'(mnv[d]), 32'(e.mn));
`endif
                    end
                end
                if (fav[d] && sev[d]) begin
                    check($sformatf("abort_and_sync[%0d]", d), 32'(fav[d] & sev[d]), 32'd0);
                end else if (fav[d] || sev[d]) begin
                    int kind;
                    kind = fav[d] ? 1 : 2;
                    if (ev_q.size() > 0 && ev_q[0].dut == d) begin
                        ev_t ev;
                        ev = ev_q.pop_front();
                        check($sformatf("pulse_kind[%0d]", d), 32'(kind), 32'(ev.kind));
                    end else begin
                        check($sformatf("unexpected_pulse[%0d]", d), 32'(kind), 32'd0);
                    end
                end
            end
            pv     <= wvv;
            pstall <= wvv & {2{~word_ready}};
            phs    <= wvv & {2{word_ready}};
            pwo[0] <= wov[0];
            pwo[1] <= wov[1];
        end
    end

    task automatic model_bit(input logic b, input logic f);
        int w;
        w = (sel != 0) ? 4 : 32;
        if (f) begin
            if (m_in[sel]) ev_q.push_back('{dut: sel, kind: 1});
            m_in[sel]  = 1'b1;
            m_acc[sel] = 32'(b);
            m_cnt[sel] = 1;
        end else if (!m_in[sel]) begin
            ev_q.push_back('{dut: sel, kind: 2});
        end else begin
            m_acc[sel] = m_acc[sel] | (32'(b) << m_cnt[sel]);
            m_cnt[sel]++;
        end
        if (m_in[sel] && m_cnt[sel] == w) begin
            exp_q.push_back('{dut: sel, data: m_acc[sel],
                              mn: (m_acc[sel] == (32'd1 << (w - 1))), stamp: cyc});
            m_in[sel]  = 1'b0;
            m_cnt[sel] = 0;
        end
    endtask

    task automatic idle(input int n);
        bv = 1'b0;
        repeat (n) begin
            fs  = 1'($urandom);
            bin = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic f);
        int   n;
        bit   ok;
        logic rdy;
        bv = 1'b1; bin = b; fs = f;
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            rdy = (sel != 0) ? br1 : br0;
            @(posedge clk);
            #1;
            n++;
            if (rdy) ok = 1;
        end
        bv = 1'b0; fs = 1'($urandom); bin = 1'($urandom);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: bit not accepted after %0d cycles, required within 200", n);
        end else begin
            model_bit(b, f);
        end
    endtask

    task automatic send_word(input logic [31:0] data, input int nbits, input bit stall, input bit gaps);
        int w;
        w = (sel != 0) ? 4 : 32;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            if (stall && i == w - 1) stall_until = cyc + 6;
            send_bit(data[i], i == 0);
        end
    endtask

    task automatic do_reset();
        bv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid32", 32'(wv0), 32'd0);
        check("rst_word32", wo0, 32'd0);
        check("rst_pulses32", 32'({fa0, se0}), 32'd0);
        check("rst_ready32", 32'(br0), 32'd1);
        check("rst_valid4", 32'(wv1), 32'd0);
        check("rst_word4", 32'(wo1), 32'd0);
        check("rst_pulses4", 32'({fa1, se1}), 32'd0);
`ifdef COLLECTOR_MINNEG_FLAG_EN
        check("rst_min_neg", 32'({mn1, mn0}), 32'd0);
`endif
        exp_q.delete();
        ev_q.delete();
        for (int d = 0; d < 2; d++) begin
            m_in[d] = 1'b0; m_cnt[d] = 0; m_acc[d] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bv = 1'b0; bin = 1'b0; fs = 1'b0; word_ready = 1'b1; sel = 0;
        for (int d = 0; d < 2; d++) begin
            m_in[d] = 1'b0; m_cnt[d] = 0; m_acc[d] = '0;
        end
        #1;
        check("reset_valid", 32'(wv0), 32'd0);
        check("reset_word", wo0, 32'd0);
        check("reset_pulses", 32'({fa0, se0, fa1, se1}), 32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain word, then back-to-back words with a consumer stall.
        send_word(32'hFFFF_D3BC, 32, 0, 0);
        idle(3);
        send_word(32'h0000_0001, 32, 1, 0);
        send_word(32'h8000_0000, 32, 0, 0);
        idle(3);

        // Partial word aborted by a new frame, then stray unframed bits in IDLE.
        send_word($urandom, 10, 0, 0);
        send_word(32'hA5A5_A5A5, 32, 0, 0);
        idle(3);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
        send_word($urandom, 32, 0, 0);
        idle(3);
        send_word(32'h1234_5678, 32, 0, 1);
        idle(3);

        for (int k = 0; k < 25; k++) begin
            rand_rdy = 1'($urandom);
            if ($urandom_range(0, 4) == 0) send_word($urandom, $urandom_range(1, 31), 0, 0);
            else if ($urandom_range(0, 4) == 0) send_bit(1'($urandom), 1'b0);
            send_word($urandom, 32, $urandom_range(0, 3) == 0, 1'($urandom));
        end
        rand_rdy = 0;
        idle(5);

        // Reset mid-word and while a word is held.
        send_word(32'hDEAD_BEEF, 20, 0, 0);
        do_reset();
        send_word(32'hCAFE_F00D, 32, 0, 0);
        idle(3);
        stall_until = cyc + 1000;
        send_word(32'h0BAD_CAFE, 32, 0, 0);
        idle(3);
        do_reset();
        stall_until = 0;
        idle(1);
        send_word(32'h5A5A_0FF0, 32, 0, 0);
        idle(3);

        // Narrow instance.
        sel = 1;
        idle(2);
        send_word(32'h8, 4, 0, 0);
        send_word(32'h5, 4, 1, 0);
        send_word(32'hF, 4, 0, 1);
        send_word(32'h2, 2, 0, 0);
        send_word(32'h3, 4, 0, 0);
        send_bit(1'b1, 1'b0);
        send_word(32'h9, 4, 0, 0);
        send_word(32'h6, 2, 0, 0);
        do_reset();
        send_word(32'hA, 4, 0, 0);
        idle(2);
        stall_until = cyc + 1000;
        send_word(32'hC, 4, 0, 0);
        idle(3);
        do_reset();
        stall_until = 0;
        idle(1);
        for (int k = 0; k < 8; k++) begin
            rand_rdy = 1'($urandom);
            send_word($urandom, 4, 0, 1'($urandom));
        end
        rand_rdy = 0;
        idle(6);

        check("words_outstanding", 32'(exp_q.size()), 32'd0);
        check("pulses_outstanding", 32'(ev_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
